// File: rtl/rf_pkg.sv
// Shared constants and address type for the CPU register file, decode and issue.
package rf_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 4;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when a producer issues,
// cleared by the matching write-back. A set on the same edge as a clear wins.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic              byp_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    input  logic              byp_b_i,
    output logic              rbusy_a_o,
    output logic              rbusy_b_o,
    output logic              any_pend_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // Next pending vector: clear on write-back, then set for a newly issued producer.
    always_comb begin
        pend_d = pend_q;
        if (clr_i) begin
            pend_d[clr_addr_i] = 1'b0;
        end
        if (set_i) begin
            pend_d[set_addr_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    // Pending register; reset clears every bit and overrides set/clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // A forwarded write satisfies the reader, so the busy flag is masked.
    always_comb begin
        rbusy_a_o  = pend_q[raddr_a_i] & ~byp_a_i;
        rbusy_b_o  = pend_q[raddr_b_i] & ~byp_b_i;
        any_pend_o = |pend_q;
    end

endmodule : rf_scoreboard

// File: rtl/register_file.sv
// Parametrised register file: one synchronous write port, two combinational
// read ports with optional same-cycle forwarding and optional hardwired zero.
module register_file
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rbusy_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rbusy_b,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic              any_pend
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic wr_en;
    logic zero_a;
    logic zero_b;
    logic byp_a;
    logic byp_b;

    // Decode the zero register, the effective write and the forwarding matches.
    always_comb begin
        zero_a = (ZERO_REG != 0) && (raddr_a == '0);
        zero_b = (ZERO_REG != 0) && (raddr_b == '0);
        wr_en  = we && !((ZERO_REG != 0) && (waddr == '0));
        byp_a  = (BYPASS != 0) && we && !reset && (waddr == raddr_a) && !zero_a;
        byp_b  = (BYPASS != 0) && we && !reset && (waddr == raddr_b) && !zero_b;
    end

    // Next array contents: the single write port updates one word.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[waddr] = wdata;
        end
    end

    // Data array; reset clears every word and drops a coincident write.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read muxes: zero register first, then forwarded write data, then the array.
    always_comb begin
        if (zero_a) begin
            rdata_a = '0;
        end else if (byp_a) begin
            rdata_a = wdata;
        end else begin
            rdata_a = mem_q[raddr_a];
        end
        if (zero_b) begin
            rdata_b = '0;
        end else if (byp_b) begin
            rdata_b = wdata;
        end else begin
            rdata_b = mem_q[raddr_b];
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (we),
        .clr_addr_i (waddr),
        .set_i      (pend_set),
        .set_addr_i (pend_addr),
        .raddr_a_i  (raddr_a),
        .byp_a_i    (byp_a),
        .raddr_b_i  (raddr_b),
        .byp_b_i    (byp_b),
        .rbusy_a_o  (rbusy_a),
        .rbusy_b_o  (rbusy_b),
        .any_pend_o (any_pend)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// Bench for register_file: three instances (forwarding, no forwarding,
// hardwired zero) share one stimulus stream and are compared every cycle
// against an array-based model, with literal expectations for the key cases.
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [3:0]  raddr_a;
    logic [3:0]  raddr_b;
    logic        pend_set;
    logic [3:0]  pend_addr;

    logic [15:0] rd_a [3];
    logic [15:0] rd_b [3];
    logic        by_a [3];
    logic        by_b [3];
    logic        anyp [3];

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    logic [15:0] mdl_mem  [3][16];
    logic        mdl_pend [3][16];

    always #5 clk = ~clk;

    // u0: forwarding, no zero reg; u1: no forwarding; u2: forwarding + zero reg
    register_file #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u0 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a[0]), .rbusy_a(by_a[0]),
        .raddr_b(raddr_b), .rdata_b(rd_b[0]), .rbusy_b(by_b[0]),
        .pend_set(pend_set), .pend_addr(pend_addr), .any_pend(anyp[0]));

    register_file #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) u1 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a[1]), .rbusy_a(by_a[1]),
        .raddr_b(raddr_b), .rdata_b(rd_b[1]), .rbusy_b(by_b[1]),
        .pend_set(pend_set), .pend_addr(pend_addr), .any_pend(anyp[1]));

    register_file #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u2 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a[2]), .rbusy_a(by_a[2]),
        .raddr_b(raddr_b), .rdata_b(rd_b[2]), .rbusy_b(by_b[2]),
        .pend_set(pend_set), .pend_addr(pend_addr), .any_pend(anyp[2]));

    function automatic bit zr_of(int k);
        return k == 2;
    endfunction

    function automatic bit bp_of(int k);
        return k != 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // What a read port must show this cycle, from the stored model state and live inputs.
    task automatic exp_read(input int k, input logic [3:0] a, output logic [15:0] d, output logic b);
        if (zr_of(k) && a == 4'd0) begin
            d = 16'h0;
            b = 1'b0;
        end else if (bp_of(k) && we && !reset && waddr == a) begin
            d = wdata;
            b = 1'b0;
        end else begin
            d = mdl_mem[k][a];
            b = mdl_pend[k][a];
        end
    endtask

    // Model state update at each rising edge.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                for (int i = 0; i < 16; i++) begin
                    mdl_mem[k][i]  <= 16'h0;
                    mdl_pend[k][i] <= 1'b0;
                end
            end else begin
                if (we && !(zr_of(k) && waddr == 4'd0)) begin
                    mdl_mem[k][waddr]  <= wdata;
                    mdl_pend[k][waddr] <= 1'b0;
                end
                if (pend_set && !(zr_of(k) && pend_addr == 4'd0)) begin
                    mdl_pend[k][pend_addr] <= 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of all outputs of all instances against the model.
    always @(negedge clk) begin
        logic [15:0] ed;
        logic        eb;
        logic        ea;
        #2;
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                exp_read(k, raddr_a, ed, eb);
                chk($sformatf("u%0d rdata_a", k), {16'h0, rd_a[k]}, {16'h0, ed});
                chk($sformatf("u%0d rbusy_a", k), {31'h0, by_a[k]}, {31'h0, eb});
                exp_read(k, raddr_b, ed, eb);
                chk($sformatf("u%0d rdata_b", k), {16'h0, rd_b[k]}, {16'h0, ed});
                chk($sformatf("u%0d rbusy_b", k), {31'h0, by_b[k]}, {31'h0, eb});
                ea = 1'b0;
                for (int i = 0; i < 16; i++) ea = ea | mdl_pend[k][i];
                chk($sformatf("u%0d any_pend", k), {31'h0, anyp[k]}, {31'h0, ea});
            end
        end
    end

    task automatic cyc(input logic rst, input logic w, input logic [3:0] wa, input logic [15:0] wd,
                       input logic ps, input logic [3:0] pa, input logic [3:0] ra, input logic [3:0] rb);
        @(negedge clk);
        reset     = rst;
        we        = w;
        waddr     = wa;
        wdata     = wd;
        pend_set  = ps;
        pend_addr = pa;
        raddr_a   = ra;
        raddr_b   = rb;
        #3;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        pend_set = 1'b0; pend_addr = '0; raddr_a = '0; raddr_b = '0;

        cyc(1, 0, 0, 16'h0, 0, 0, 0, 0);
        chk_en = 1;
        cyc(1, 1, 2, 16'h1111, 1, 2, 2, 2);

        // every address reads zero and idle after reset
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0, 16'h0, 0, 0, 4'(i), 4'(15 - i));
            chk("rst rdata_a", {16'h0, rd_a[0]}, 32'h0);
            chk("rst rdata_b", {16'h0, rd_b[1]}, 32'h0);
            chk("rst rbusy_a", {31'h0, by_a[0]}, 32'h0);
            chk("rst any_pend", {31'h0, anyp[0]}, 32'h0);
        end

        // same-cycle forwarding vs next-cycle visibility
        cyc(0, 1, 5, 16'hBEEF, 0, 0, 5, 5);
        chk("bypass rdata_a", {16'h0, rd_a[0]}, 32'hBEEF);
        chk("nobypass old rdata_a", {16'h0, rd_a[1]}, 32'h0);
        cyc(0, 0, 0, 16'h0, 0, 0, 5, 5);
        chk("nobypass next rdata_a", {16'h0, rd_a[1]}, 32'hBEEF);

        // pending on reg 3, cleared by write-back two cycles later
        cyc(0, 0, 0, 16'h0, 1, 3, 3, 3);
        chk("pend issue-cycle rbusy_a", {31'h0, by_a[0]}, 32'h0);
        cyc(0, 0, 0, 16'h0, 0, 0, 3, 3);
        chk("pend c1 rbusy_a", {31'h0, by_a[0]}, 32'h1);
        cyc(0, 0, 0, 16'h0, 0, 0, 3, 3);
        chk("pend c2 rbusy_a", {31'h0, by_a[0]}, 32'h1);
        cyc(0, 1, 3, 16'h1234, 0, 0, 3, 3);
        chk("wb cycle rbusy_a", {31'h0, by_a[0]}, 32'h0);
        chk("wb cycle rdata_a", {16'h0, rd_a[0]}, 32'h1234);
        cyc(0, 0, 0, 16'h0, 0, 0, 3, 3);
        chk("after wb rbusy_a", {31'h0, by_a[0]}, 32'h0);
        chk("after wb rdata_b", {16'h0, rd_b[0]}, 32'h1234);

        // set wins over clear on the same register
        cyc(0, 1, 7, 16'h00AA, 1, 7, 7, 7);
        cyc(0, 0, 0, 16'h0, 0, 0, 7, 7);
        chk("setwins rdata_a", {16'h0, rd_a[0]}, 32'h00AA);
        chk("setwins rbusy_a", {31'h0, by_a[0]}, 32'h1);
        chk("setwins any_pend", {31'h0, anyp[0]}, 32'h1);
        cyc(0, 1, 7, 16'h00BB, 0, 0, 7, 7);
        cyc(0, 0, 0, 16'h0, 0, 0, 7, 7);
        chk("clr rbusy_a", {31'h0, by_a[0]}, 32'h0);
        chk("clr any_pend", {31'h0, anyp[0]}, 32'h0);
        chk("clr rdata_a", {16'h0, rd_a[0]}, 32'h00BB);

        // hardwired zero register vs ordinary register 0
        cyc(0, 1, 0, 16'hFFFF, 1, 0, 0, 0);
        cyc(0, 0, 0, 16'h0, 0, 0, 0, 0);
        chk("zr rdata_a", {16'h0, rd_a[2]}, 32'h0);
        chk("zr rbusy_a", {31'h0, by_a[2]}, 32'h0);
        chk("zr any_pend", {31'h0, anyp[2]}, 32'h0);
        chk("nozr rdata_a", {16'h0, rd_a[0]}, 32'hFFFF);

        // reset beats a coincident write and suppresses forwarding
        cyc(0, 1, 9, 16'h5555, 0, 0, 9, 9);
        cyc(1, 1, 9, 16'hAAAA, 0, 0, 9, 9);
        chk("rst cycle rdata_a", {16'h0, rd_a[0]}, 32'h5555);
        cyc(0, 0, 0, 16'h0, 0, 0, 9, 9);
        chk("post rst rdata_a", {16'h0, rd_a[0]}, 32'h0);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 1) == 1),
                4'($urandom_range(0, 15)),
                16'($urandom),
                ($urandom_range(0, 9) < 3),
                4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_register_file
